// File: rtl/calc_seq.sv
// calc_seq: registered WIDTH-bit ALU with an iterative 1-bit-per-cycle shifter
// behind a start/done handshake; produces result, write enable and {S,Z,C,V}.
module calc_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       code,
    output logic             wr_en
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_CMP = 4'b0101;
    localparam logic [3:0] OP_MOV = 4'b0110;

    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SLR = 2'b01;
    localparam logic [1:0] SH_SRL = 2'b10;
    localparam logic [1:0] SH_SRA = 2'b11;

    localparam logic [SHW-1:0] CNT_ZERO = {SHW{1'b0}};
    localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
    localparam int             MSB      = WIDTH - 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] work_r;
    logic [SHW-1:0]   cnt_r;
    logic [1:0]       shop_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] result_r;
    logic [3:0]       code_r;
    logic             wr_en_r;

    logic [WIDTH:0]   ext_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_c_s;
    logic             alu_v_s;
    logic             alu_def_s;
    logic             alu_we_s;
    logic             is_shift_s;
    logic [WIDTH-1:0] step_s;
    logic             step_c_s;

    // Condition code {S,Z,C,V} from a final result and its carry/overflow bits.
    function automatic logic [3:0] flags_f(input logic [WIDTH-1:0] r,
                                           input logic c,
                                           input logic v);
        flags_f = {r[MSB], (r == {WIDTH{1'b0}}), c, v};
    endfunction

    assign is_shift_s = (op[3:2] == 2'b10);

    // Single-cycle ALU for the non-shift functions.
    always_comb begin
        ext_s     = {(WIDTH+1){1'b0}};
        alu_res_s = {WIDTH{1'b0}};
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
        alu_def_s = 1'b1;
        alu_we_s  = 1'b1;
        case (op)
            OP_ADD: begin
                ext_s     = {1'b0, a} + {1'b0, b};
                alu_res_s = ext_s[WIDTH-1:0];
                alu_c_s   = ext_s[WIDTH];
                alu_v_s   = (a[MSB] == b[MSB]) && (ext_s[MSB] != a[MSB]);
            end
            OP_SUB, OP_CMP: begin
                // b-a: the extra top bit of the widened difference is the borrow
                ext_s     = {1'b0, b} - {1'b0, a};
                alu_res_s = ext_s[WIDTH-1:0];
                alu_c_s   = ext_s[WIDTH];
                alu_v_s   = (a[MSB] != b[MSB]) && (ext_s[MSB] != b[MSB]);
                alu_we_s  = (op == OP_SUB);
            end
            OP_AND: alu_res_s = a & b;
            OP_OR:  alu_res_s = a | b;
            OP_XOR: alu_res_s = a ^ b;
            OP_MOV: alu_res_s = b;
            default: begin
                alu_def_s = 1'b0;
                alu_we_s  = 1'b0;
            end
        endcase
    end

    // One-bit shift step of the working register and the bit it pushes out.
    always_comb begin
        step_s   = work_r;
        step_c_s = 1'b0;
        case (shop_r)
            SH_SLL: begin
                step_s   = {work_r[WIDTH-2:0], 1'b0};
                step_c_s = work_r[MSB];
            end
            SH_SLR: begin
                step_s   = {work_r[WIDTH-2:0], work_r[MSB]};
                step_c_s = 1'b0;
            end
            SH_SRL: begin
                step_s   = {1'b0, work_r[WIDTH-1:1]};
                step_c_s = work_r[0];
            end
            SH_SRA: begin
                step_s   = {work_r[MSB], work_r[WIDTH-1:1]};
                step_c_s = work_r[0];
            end
            default: begin
                step_s   = work_r;
                step_c_s = 1'b0;
            end
        endcase
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            work_r   <= {WIDTH{1'b0}};
            cnt_r    <= CNT_ZERO;
            shop_r   <= 2'b00;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= {WIDTH{1'b0}};
            code_r   <= 4'b0000;
            wr_en_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    busy_r <= 1'b0;
                    if (start) begin
                        if (is_shift_s) begin
                            work_r <= b;
                            cnt_r  <= shamt;
                            shop_r <= op[1:0];
                            if (shamt == CNT_ZERO) begin
                                state_r  <= IDLE;
                                done_r   <= 1'b1;
                                result_r <= b;
                                code_r   <= flags_f(b, 1'b0, 1'b0);
                                wr_en_r  <= 1'b1;
                            end else begin
                                state_r <= SHIFT;
                                busy_r  <= 1'b1;
                                done_r  <= 1'b0;
                            end
                        end else begin
                            state_r  <= IDLE;
                            done_r   <= 1'b1;
                            result_r <= alu_res_s;
                            code_r   <= alu_def_s ? flags_f(alu_res_s, alu_c_s, alu_v_s) : 4'b0000;
                            wr_en_r  <= alu_we_s;
                        end
                    end else begin
                        done_r <= 1'b0;
                    end
                end
                SHIFT: begin
                    // start is ignored here; the shift in flight runs to completion
                    work_r <= step_s;
                    cnt_r  <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_r  <= IDLE;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        result_r <= step_s;
                        code_r   <= flags_f(step_s, step_c_s, 1'b0);
                        wr_en_r  <= 1'b1;
                    end else begin
                        state_r <= SHIFT;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign code   = code_r;
    assign wr_en  = wr_en_r;

endmodule

// File: tb/tb_calc_seq.sv
// Self-checking bench for calc_seq: directed literal cases plus randomized
// traffic compared every cycle against a whole-operation reference model.
module tb_calc_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  shamt;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [3:0]  code;
    logic        wr_en;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    typedef struct packed {
        logic [15:0] res;
        logic [3:0]  code;
        logic        we;
    } exp_t;

    exp_t m_out  = '0;
    exp_t m_pend = '0;
    int   m_left = 0;
    logic m_done = 1'b0;

    calc_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .shamt(shamt), .busy(busy), .done(done), .result(result),
        .code(code), .wr_en(wr_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Whole-operation result computed directly from the arithmetic definitions.
    function automatic exp_t calc(input logic [3:0] o, input logic [15:0] aa,
                                  input logic [15:0] bb, input logic [3:0] sh);
        exp_t e;
        logic [16:0] u;
        logic [15:0] r;
        int sa, sb, s;
        logic cf, vf, def;
        sa = int'($signed(aa));
        sb = int'($signed(bb));
        r = 16'h0000; cf = 1'b0; vf = 1'b0; def = 1'b1; e.we = 1'b1;
        case (o)
            4'd0: begin
                u = {1'b0, aa} + {1'b0, bb};
                r = u[15:0]; cf = u[16];
                s = sa + sb; vf = (s > 32767) || (s < -32768);
            end
            4'd1, 4'd5: begin
                r = bb - aa; cf = (bb < aa);
                s = sb - sa; vf = (s > 32767) || (s < -32768);
                e.we = (o == 4'd1);
            end
            4'd2: r = aa & bb;
            4'd3: r = aa | bb;
            4'd4: r = aa ^ bb;
            4'd6: r = bb;
            4'd8: begin
                r = bb << sh;
                cf = (sh != 4'd0) ? bb[16 - int'(sh)] : 1'b0;
            end
            4'd9: r = (sh == 4'd0) ? bb : ((bb << sh) | (bb >> (16 - int'(sh))));
            4'd10: begin
                r = bb >> sh;
                cf = (sh != 4'd0) ? bb[int'(sh) - 1] : 1'b0;
            end
            4'd11: begin
                r = $signed(bb) >>> sh;
                cf = (sh != 4'd0) ? bb[int'(sh) - 1] : 1'b0;
            end
            default: begin def = 1'b0; e.we = 1'b0; end
        endcase
        e.res  = def ? r : 16'h0000;
        e.code = def ? {r[15], (r == 16'h0000), cf, vf} : 4'b0000;
        return e;
    endfunction

    // Reference model: an accepted op completes after shamt extra cycles for shifts.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_left <= 0; m_done <= 1'b0; m_out <= '0; m_pend <= '0;
        end else if (m_left == 0 && start) begin
            if (op[3:2] == 2'b10 && shamt != 4'd0) begin
                m_pend <= calc(op, a, b, shamt);
                m_left <= int'(shamt);
                m_done <= 1'b0;
            end else begin
                m_out  <= calc(op, a, b, shamt);
                m_done <= 1'b1;
            end
        end else if (m_left > 1) begin
            m_left <= m_left - 1;
            m_done <= 1'b0;
        end else if (m_left == 1) begin
            m_left <= 0;
            m_done <= 1'b1;
            m_out  <= m_pend;
        end else begin
            m_done <= 1'b0;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("m_done",   32'(done),   32'(m_done));
            chk("m_busy",   32'(busy),   32'(m_left != 0));
            chk("m_result", 32'(result), 32'(m_out.res));
            chk("m_code",   32'(code),   32'(m_out.code));
            chk("m_wr_en",  32'(wr_en),  32'(m_out.we));
        end
    end

    task automatic run_op(input string nm, input logic [3:0] o, input logic [15:0] aa,
                          input logic [15:0] bb, input logic [3:0] sh,
                          input logic [15:0] er, input logic [3:0] ec, input logic ewe,
                          input int elat, input int ebusy);
        int lat, nb;
        start = 1'b1; op = o; a = aa; b = bb; shamt = sh;
        @(negedge clk);
        start = 1'b0;
        lat = 1; nb = 0;
        while (!done && lat < 40) begin
            if (busy) nb++;
            @(negedge clk);
            lat++;
        end
        chk({nm, "_lat"},    32'(lat),    32'(elat));
        chk({nm, "_busy"},   32'(nb),     32'(ebusy));
        chk({nm, "_result"}, 32'(result), 32'(er));
        chk({nm, "_code"},   32'(code),   32'(ec));
        chk({nm, "_wr_en"},  32'(wr_en),  32'(ewe));
        @(negedge clk);
        chk({nm, "_pulse"},  32'(done),   32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        rst_n = 1'b0; start = 1'b0; op = 4'd0; a = 16'h0; b = 16'h0; shamt = 4'd0;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        chk("rst_done",   32'(done),   32'd0);
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_code",   32'(code),   32'd0);
        chk("rst_wr_en",  32'(wr_en),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("add", 4'd0,  16'h0001, 16'h7FFF, 4'd0, 16'h8000, 4'b1001, 1'b1, 1, 0);
        run_op("sub", 4'd1,  16'h0005, 16'h0003, 4'd0, 16'hFFFE, 4'b1010, 1'b1, 1, 0);
        run_op("cmp", 4'd5,  16'h1234, 16'h1234, 4'd0, 16'h0000, 4'b0100, 1'b0, 1, 0);
        run_op("sra", 4'd11, 16'h0000, 16'h8009, 4'd4, 16'hF800, 4'b1010, 1'b1, 5, 4);
        run_op("sll", 4'd8,  16'h0000, 16'h01FF, 4'd8, 16'hFF00, 4'b1010, 1'b1, 9, 8);
        run_op("slr", 4'd9,  16'h0000, 16'h8001, 4'd1, 16'h0003, 4'b0000, 1'b1, 2, 1);
        run_op("sh0", 4'd10, 16'h0000, 16'h8000, 4'd0, 16'h8000, 4'b1000, 1'b1, 1, 0);

        // SRL 15 with an ADD start pulsed while busy: the ADD must be dropped.
        start = 1'b1; op = 4'd10; a = 16'h0; b = 16'hABCD; shamt = 4'd15;
        @(negedge clk);
        start = 1'b0; lat = 1;
        @(negedge clk); lat++;
        start = 1'b1; op = 4'd0; a = 16'h1111; b = 16'h2222;
        @(negedge clk); lat++;
        start = 1'b0;
        while (!done && lat < 40) begin @(negedge clk); lat++; end
        chk("srl_lat",    32'(lat),    32'd16);
        chk("srl_result", 32'(result), 32'h0001);
        chk("srl_code",   32'(code),   32'h0);
        @(negedge clk);
        chk("srl_nodup",  32'(done),   32'd0);

        // Reset in the middle of a shift discards it.
        start = 1'b1; op = 4'd8; b = 16'h1234; shamt = 4'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_done",   32'(done),   32'd0);
        chk("mid_rst_busy",   32'(busy),   32'd0);
        chk("mid_rst_result", 32'(result), 32'd0);
        chk("mid_rst_code",   32'(code),   32'd0);
        chk("mid_rst_wr_en",  32'(wr_en),  32'd0);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            chk("mid_rst_nodone", 32'(done), 32'd0);
        end
        run_op("undef", 4'd7, 16'hFFFF, 16'h1234, 4'd0, 16'h0000, 4'b0000, 1'b0, 1, 0);

        // Randomized traffic; the every-cycle compare checks it all.
        for (int i = 0; i < 1500; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            start = ($urandom_range(0, 2) == 0);
            op    = 4'($urandom_range(0, 15));
            a     = 16'($urandom);
            b     = 16'($urandom);
            shamt = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            @(negedge clk);
        end
        rst_n = 1'b1; start = 1'b0;
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/calc_seq.md
Name: calc_seq

Overview:
- Parametrised, registered successor to the 16-bit combinational calculator: WIDTH-bit ALU plus an iterative shifter behind a start/done handshake.
- Sits between the register-file read stage and the writeback stage. Provides a registered result, write enable and an {S,Z,C,V} condition code.
- Shifts run 1 bit per cycle, so the block is shared and needs no wide barrel shifter.
- Defines flags for every op, including shifts.

Parameters:
WIDTH, 16, datapath width; power of 2, >= 8
SHW, $clog2(WIDTH), shift-amount width (derived; do not override)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous reset, active-low
start  in  1  accept op/a/b/shamt this cycle when busy=0
op  in  4  function: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 CMP, 0110 MOV, 1000 SLL, 1001 SLR (rotate left), 1010 SRL, 1011 SRA; others undefined
a  in  WIDTH  operand A
b  in  WIDTH  operand B / shift source
shamt  in  SHW  shift count
busy  out  1  high while a shift is iterating
done  out  1  one-cycle pulse; result/code/wr_en valid and held until the next done
result  out  WIDTH  registered result
code  out  4  registered {S,Z,C,V}
wr_en  out  1  high with done if the result is to be written back

Behaviour:
- Reset: rst_n=0 at a clock edge forces state IDLE and clears busy, done, result, code and wr_en to 0. This applies at any time, including mid-shift; the operation in flight is discarded and produces no done.
- States: IDLE, SHIFT.
- IDLE + start + non-shift op:
  - Computes and registers the result the same edge.
  - done=1 the next cycle (latency 1); stays in IDLE.
- ADD: x = a+b over WIDTH+1 bits.
  - C = carry out.
  - V = 1 if a,b same sign and result sign differs.
- SUB: x = b-a.
  - C = borrow out, i.e. 1 when b < a unsigned.
  - V = 1 if a,b signs differ and result sign differs from b.
- CMP: flags computed as SUB; wr_en=0; result = b-a.
- AND/OR/XOR/MOV: result a&b, a|b, a^b, b respectively; C=0, V=0.
- S = result MSB and Z = (result==0) for all defined ops.
- Undefined op: done pulses after 1 cycle; result=0, code=0000, wr_en=0.
- wr_en=1 with done for all defined ops except CMP.
- IDLE + start + shift op:
  - Latches b into a working register and shamt into a counter.
  - shamt=0: behaves like a 1-cycle op; result=b, C=0.
  - Otherwise go to SHIFT with busy=1. Each cycle shifts 1 bit and decrements the counter.
  - When the counter reaches 0, registers result/code, returns to IDLE and sets busy=0. done is asserted that cycle.
  - Total latency: shamt+1 cycles from the start edge to the done cycle.
- Shift fill and carry:
  - SLL: fill 0; C = last bit shifted out of the MSB.
  - SRL: fill 0; C = last bit shifted out of the LSB.
  - SRA: fill with the sign bit; C = last bit shifted out of the LSB.
  - SLR: rotates; C=0.
  - All shifts: V=0, S/Z from the final result.
- start while busy=1 is ignored; the operation in flight is unaffected.
- start in the same cycle as done is accepted.
- Outputs hold their values between done pulses. done never stays high for 2 consecutive cycles unless a new op completes.

Test Plan:
- ADD a=0x0001 b=0x7FFF -> done 1 cycle later; result 0x8000, code 1001, wr_en=1.
- SUB a=0x0005 b=0x0003 -> result 0xFFFE, code 1010. Then CMP a=b=0x1234 -> result 0x0000, code 0100, wr_en=0.
- SRA b=0x8009 shamt=4:
  - busy high for 4 cycles; done on cycle 5.
  - result 0xF800, code 1010.
- SLL b=0x01FF shamt=8 -> done on cycle 9; result 0xFF00, code 1010. SLR b=0x8001 shamt=1 -> result 0x0003, code 0000.
- Start SRL shamt=15, pulse start with ADD at cycle 3 -> ADD ignored; only SRL done at cycle 16.
- Start SLL shamt=10, drive rst_n=0 at cycle 4 -> all outputs 0 next cycle, no done pulse. Then undefined op 0x7 -> done, result 0, code 0000, wr_en=0.
